// File: rtl/astc_weight_infill.sv
`default_nettype none
// ============================================================================
// Module   : astc_weight_infill
// Brief    : Bilinear infill of an ASTC weight grid onto the block texels,
//            LANES texels per cycle, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module astc_weight_infill #(
    parameter int MAX_TEXELS = 144,
    parameter int MAX_GRID   = 64,
    parameter int LANES      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              cfg_block_w,
    input  logic [3:0]              cfg_block_h,
    input  logic [3:0]              cfg_grid_w,
    input  logic [3:0]              cfg_grid_h,
    input  logic [MAX_TEXELS*8-1:0] in_grid_u8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MAX_TEXELS*8-1:0] out_weights_u8,
    output logic                    out_err
);
    localparam int IW = $clog2(MAX_TEXELS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                grid_q [MAX_TEXELS];
    logic [7:0]                grid_d [MAX_TEXELS];
    logic [3:0]                bw_q, bw_d, bh_q, bh_d, gw_q, gw_d, gh_q, gh_d;
    logic [3:0]                s_q, s_d, t_q, t_d;
    logic [7:0]                idx_q, idx_d;
    logic [MAX_TEXELS*8-1:0]   out_q, out_d;
    logic                      err_q, err_d;

    logic                      cfg_illegal;
    logic [7:0]                total;
    logic [8:0]                ds, dt;
    logic [3:0]                lane_s [LANES];
    logic [3:0]                lane_t [LANES];
    logic [3:0]                s_nxt, t_nxt;
    logic [LANES-1:0]          lane_act;
    logic [LANES*8-1:0]        lane_res;

    // Ds/Dt: (1024 + n/2) / (n - 1), the fixed-point step across the block
    function automatic logic [8:0] recip(input logic [3:0] n);
        case (n)
            4'd4:    recip = 9'd342;
            4'd5:    recip = 9'd256;
            4'd6:    recip = 9'd205;
            4'd7:    recip = 9'd171;
            4'd8:    recip = 9'd146;
            4'd9:    recip = 9'd128;
            4'd10:   recip = 9'd114;
            4'd11:   recip = 9'd102;
            4'd12:   recip = 9'd93;
            default: recip = 9'd0;
        endcase
    endfunction

    function automatic logic [7:0] tap(input logic [4:0] c, input logic [4:0] r);
        logic [7:0] v;
        v   = 8'(r) * 8'(gw_q) + 8'(c);
        tap = (c < {1'b0, gw_q} && r < {1'b0, gh_q}) ? grid_q[IW'(v)] : 8'd0;
    endfunction

    assign cfg_illegal = (cfg_block_w < 4'd4) || (cfg_block_w > 4'd12) ||
                         (cfg_block_h < 4'd4) || (cfg_block_h > 4'd12) ||
                         (cfg_grid_w < 4'd2)  || (cfg_grid_w > cfg_block_w) ||
                         (cfg_grid_h < 4'd2)  || (cfg_grid_h > cfg_block_h) ||
                         ({4'd0, cfg_grid_w} * {4'd0, cfg_grid_h} > 8'(MAX_GRID));

    assign total = {4'd0, bw_q} * {4'd0, bh_q};
    assign ds    = recip(bw_q);
    assign dt    = recip(bh_q);

    // Walk (s,t) across the beat; Bw >= LANES so at most one row wrap per beat
    always_comb begin
        logic [3:0] cs, ct;
        cs = s_q;
        ct = t_q;
        for (int l = 0; l < LANES; l++) begin
            lane_s[l]   = cs;
            lane_t[l]   = ct;
            lane_act[l] = ({1'b0, idx_q} + 9'(l)) < {1'b0, total};
            if (cs == bw_q - 4'd1) begin
                cs = 4'd0;
                ct = ct + 4'd1;
            end else begin
                cs = cs + 4'd1;
            end
        end
        s_nxt = cs;
        t_nxt = ct;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [15:0] ps, pt;
        logic [7:0]  gs, gt;
        logic [3:0]  js, jt, fs, ft;
        logic [4:0]  w00, w01, w10, w11;
        logic [7:0]  p00, p01, p10, p11;
        logic [12:0] acc;

        always_comb begin
            ps  = 16'(ds) * 16'(lane_s[l]) * 16'(gw_q - 4'd1);
            pt  = 16'(dt) * 16'(lane_t[l]) * 16'(gh_q - 4'd1);
            gs  = 8'((ps + 16'd32) >> 6);
            gt  = 8'((pt + 16'd32) >> 6);
            js  = gs[7:4];
            fs  = gs[3:0];
            jt  = gt[7:4];
            ft  = gt[3:0];
            w11 = 5'(({4'd0, fs} * {4'd0, ft} + 8'd8) >> 4);
            w10 = {1'b0, ft} - w11;
            w01 = {1'b0, fs} - w11;
            w00 = 5'd16 - {1'b0, fs} - {1'b0, ft} + w11;
            p00 = tap({1'b0, js},         {1'b0, jt});
            p01 = tap({1'b0, js} + 5'd1,  {1'b0, jt});
            p10 = tap({1'b0, js},         {1'b0, jt} + 5'd1);
            p11 = tap({1'b0, js} + 5'd1,  {1'b0, jt} + 5'd1);
            acc = 13'(p00) * 13'(w00) + 13'(p01) * 13'(w01) +
                  13'(p10) * 13'(w10) + 13'(p11) * 13'(w11) + 13'd8;
        end

        assign lane_res[l*8 +: 8] = 8'(acc >> 4);
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        gw_d    = gw_q;
        gh_d    = gh_q;
        s_d     = s_q;
        t_d     = t_q;
        idx_d   = idx_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < MAX_TEXELS; i++) grid_d[i] = in_grid_u8[i*8 +: 8];
                    bw_d    = cfg_block_w;
                    bh_d    = cfg_block_h;
                    gw_d    = cfg_grid_w;
                    gh_d    = cfg_grid_h;
                    s_d     = 4'd0;
                    t_d     = 4'd0;
                    idx_d   = 8'd0;
                    out_d   = '0;
                    err_d   = cfg_illegal;
                    state_d = cfg_illegal ? DONE : RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    if (lane_act[l])
                        out_d[(({3'd0, idx_q} + 11'(l)) * 11'd8) +: 8] = lane_res[l*8 +: 8];
                end
                s_d   = s_nxt;
                t_d   = t_nxt;
                idx_d = idx_q + 8'(LANES);
                if ({1'b0, idx_q} + 9'(LANES) >= {1'b0, total}) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < MAX_TEXELS; i++) grid_q[i] <= 8'd0;
            bw_q    <= 4'd0;
            bh_q    <= 4'd0;
            gw_q    <= 4'd0;
            gh_q    <= 4'd0;
            s_q     <= 4'd0;
            t_q     <= 4'd0;
            idx_q   <= 8'd0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            gw_q    <= gw_d;
            gh_q    <= gh_d;
            s_q     <= s_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign out_weights_u8 = out_q;
    assign out_err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_astc_weight_infill.sv
`default_nettype none
// ============================================================================
// Module   : tb_astc_weight_infill
// Brief    : Table-driven and randomized self-checking bench for the infill.
// Revision : 1.0
// ============================================================================
module tb_astc_weight_infill;
    localparam int MAX_TEXELS = 144;
    localparam int MAX_GRID   = 64;
    localparam int LANES      = 4;
    localparam int BW         = MAX_TEXELS * 8;

    typedef struct {
        int           bw, bh, gw, gh;
        logic [BW-1:0] grid;
        logic [BW-1:0] exp_w;
        bit           exp_err;
        int           exp_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [3:0]    cfg_block_w, cfg_block_h, cfg_grid_w, cfg_grid_h;
    logic [BW-1:0] in_grid_u8, out_weights_u8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    astc_weight_infill #(.MAX_TEXELS(MAX_TEXELS), .MAX_GRID(MAX_GRID), .LANES(LANES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .cfg_block_w    (cfg_block_w),
        .cfg_block_h    (cfg_block_h),
        .cfg_grid_w     (cfg_grid_w),
        .cfg_grid_h     (cfg_grid_h),
        .in_grid_u8     (in_grid_u8),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_weights_u8 (out_weights_u8),
        .out_err        (out_err)
    );

    function automatic bit legal(int bw, int bh, int gw, int gh);
        return bw >= 4 && bw <= 12 && bh >= 4 && bh <= 12 && gw >= 2 && gw <= bw &&
               gh >= 2 && gh <= bh && gw * gh <= MAX_GRID;
    endfunction

    function automatic int tap(logic [BW-1:0] g, int gw, int gh, int c, int r);
        if (c < gw && r < gh) return int'(g[(r*gw+c)*8 +: 8]);
        return 0;
    endfunction

    // Reference infill: evaluates each texel directly from its (s,t) position.
    function automatic logic [BW-1:0] model(int bw, int bh, int gw, int gh, logic [BW-1:0] g);
        logic [BW-1:0] r;
        int ds, dt, gs, gt, js, jt, fs, ft, w00, w01, w10, w11, acc;
        r = '0;
        if (!legal(bw, bh, gw, gh)) return r;
        ds = (1024 + bw / 2) / (bw - 1);
        dt = (1024 + bh / 2) / (bh - 1);
        for (int t = 0; t < bh; t++) begin
            for (int s = 0; s < bw; s++) begin
                gs  = (ds * s * (gw - 1) + 32) >> 6;
                gt  = (dt * t * (gh - 1) + 32) >> 6;
                js  = gs >> 4;  fs = gs & 15;
                jt  = gt >> 4;  ft = gt & 15;
                w11 = (fs * ft + 8) >> 4;
                w10 = ft - w11;
                w01 = fs - w11;
                w00 = 16 - fs - ft + w11;
                acc = tap(g, gw, gh, js, jt) * w00 + tap(g, gw, gh, js + 1, jt) * w01 +
                      tap(g, gw, gh, js, jt + 1) * w10 + tap(g, gw, gh, js + 1, jt + 1) * w11 + 8;
                r[(t*bw+s)*8 +: 8] = 8'(acc >> 4);
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] r;
        for (int i = 0; i < MAX_TEXELS; i++) r[i*8 +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic vec_t make_vec(int bw, int bh, int gw, int gh, logic [BW-1:0] g);
        vec_t v;
        v.bw = bw; v.bh = bh; v.gw = gw; v.gh = gh; v.grid = g;
        v.exp_w   = model(bw, bh, gw, gh, g);
        v.exp_err = !legal(bw, bh, gw, gh);
        v.exp_lat = v.exp_err ? 0 : (bw * bh + LANES - 1) / LANES;
        return v;
    endfunction

    task automatic check_val(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_bus(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            for (int i = 0; i < MAX_TEXELS; i++) begin
                if (act[i*8 +: 8] !== req[i*8 +: 8]) begin
                    $display("FAIL %s texel %0d actual=%0d required=%0d", nm, i,
                             act[i*8 +: 8], req[i*8 +: 8]);
                    break;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_block(input vec_t v, input string nm);
        int waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check_val({nm, " in_ready"}, int'(in_ready), 1);
        cfg_block_w = 4'(v.bw); cfg_block_h = 4'(v.bh);
        cfg_grid_w  = 4'(v.gw); cfg_grid_h  = 4'(v.gh);
        in_grid_u8  = v.grid;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        cfg_block_w = 4'($urandom); cfg_block_h = 4'($urandom);
        cfg_grid_w  = 4'($urandom); cfg_grid_h  = 4'($urandom);
        in_grid_u8  = rand_bus();
    endtask

    task automatic wait_done(input vec_t v, input string nm);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check_val({nm, " latency"}, lat, v.exp_lat);
        check_val({nm, " out_err"}, int'(out_err), int'(v.exp_err));
        check_bus({nm, " weights"}, out_weights_u8, v.exp_w);
    endtask

    task automatic finish_block(input vec_t v, input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({nm, " out_valid drop"}, int'(out_valid), 0);
        check_bus({nm, " weights held"}, out_weights_u8, v.exp_w);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        start_block(v, nm);
        wait_done(v, nm);
        finish_block(v, nm);
    endtask

    vec_t vecs[6];
    string names[6] = '{"ident4x4", "grid2x2", "flat12x12", "rand5x5", "grid9x8", "bw3"};

    initial begin
        logic [BW-1:0] g;
        vec_t v;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_block_w = '0; cfg_block_h = '0; cfg_grid_w = '0; cfg_grid_h = '0;
        in_grid_u8 = '0;
        repeat (3) @(negedge clk);
        check_val("reset in_ready", int'(in_ready), 1);
        check_val("reset out_valid", int'(out_valid), 0);
        check_val("reset out_err", int'(out_err), 0);
        check_bus("reset weights", out_weights_u8, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: expected values for the first three are written by hand.
        g = rand_bus();
        for (int i = 0; i < 16; i++) g[i*8 +: 8] = 8'(i * 4);
        vecs[0] = '{bw:4, bh:4, gw:4, gh:4, grid:g, exp_w:'0, exp_err:0, exp_lat:4};
        for (int i = 0; i < 16; i++) vecs[0].exp_w[i*8 +: 8] = 8'(i * 4);

        g = rand_bus();
        g[31:0] = {8'd64, 8'd0, 8'd64, 8'd0};
        vecs[1] = '{bw:4, bh:4, gw:2, gh:2, grid:g, exp_w:'0, exp_err:0, exp_lat:4};
        for (int t = 0; t < 4; t++) vecs[1].exp_w[t*32 +: 32] = {8'd64, 8'd44, 8'd20, 8'd0};

        g = rand_bus();
        for (int i = 0; i < 64; i++) g[i*8 +: 8] = 8'd200;
        vecs[2] = '{bw:12, bh:12, gw:8, gh:8, grid:g, exp_w:'0, exp_err:0, exp_lat:36};
        for (int i = 0; i < 144; i++) vecs[2].exp_w[i*8 +: 8] = 8'd200;

        vecs[3] = make_vec(5, 5, 3, 3, rand_bus());
        vecs[3].exp_lat = 7;
        vecs[4] = '{bw:12, bh:12, gw:9, gh:8, grid:rand_bus(), exp_w:'0, exp_err:1, exp_lat:0};
        vecs[5] = '{bw:3, bh:4, gw:2, gh:2, grid:rand_bus(), exp_w:'0, exp_err:1, exp_lat:0};

        for (int i = 0; i < 6; i++) run_vec(vecs[i], names[i]);

        // Randomized configs against the reference model, illegal ones included.
        for (int i = 0; i < 12; i++) begin
            int bw, bh;
            bw = $urandom_range(4, 12);
            bh = $urandom_range(4, 12);
            v  = make_vec(bw, bh, $urandom_range(2, bw), $urandom_range(2, bh), rand_bus());
            run_vec(v, $sformatf("rand%0d_%0dx%0d", i, bw, bh));
        end

        // Back-pressure in DONE: outputs frozen, new requests ignored.
        v = make_vec(6, 4, 3, 2, rand_bus());
        start_block(v, "hold");
        wait_done(v, "hold");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            cfg_block_w = 4'd8; cfg_block_h = 4'd8; cfg_grid_w = 4'd4; cfg_grid_h = 4'd4;
            @(negedge clk);
            check_val($sformatf("hold c%0d out_valid", c), int'(out_valid), 1);
            check_val($sformatf("hold c%0d in_ready", c), int'(in_ready), 0);
            check_bus($sformatf("hold c%0d weights", c), out_weights_u8, v.exp_w);
        end
        in_valid = 1'b0;
        finish_block(v, "hold");

        // Reset pulse mid-RUN discards the partial block.
        v = make_vec(12, 12, 7, 5, rand_bus());
        start_block(v, "midrst");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst in_ready", int'(in_ready), 1);
        check_val("midrst out_valid", int'(out_valid), 0);
        check_val("midrst out_err", int'(out_err), 0);
        check_bus("midrst weights", out_weights_u8, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(make_vec(9, 7, 5, 4, rand_bus()), "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/astc_weight_infill.md
# astc_weight_infill

Stage directly downstream of weight unquantization in the ASTC decode path. Takes the unquantized weight-grid values (grid dimensions Gw x Gh ≤ block dimensions) and bilinearly infills them onto the full Bw x Bh texel grid, using the ASTC fixed-point infill procedure. Its output is the per-texel weight bus consumed by endpoint interpolation. The block is iterative: LANES texels per cycle, with a valid/ready handshake on both sides.

## Interface
- MAX_TEXELS, 144: max texels per block and size of the grid-weight input bus.
- MAX_GRID, 64: max grid weights (Gw*Gh).
- LANES, 4: texels computed per RUN cycle; legal values are 1, 2, 4.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  grid weights and config valid.
- in_ready  out  1  high iff state==IDLE.
- cfg_block_w  in  4  Bw, legal range 4..12.
- cfg_block_h  in  4  Bh, legal range 4..12.
- cfg_grid_w  in  4  Gw, legal range 2..Bw.
- cfg_grid_h  in  4  Gh, legal range 2..Bh.
- in_grid_u8  in  MAX_TEXELS*8  grid weights, row-major, index = r*Gw+c, 8 bits each; entries ≥ Gw*Gh are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_weights_u8  out  MAX_TEXELS*8  per-texel weights, index = t*Bw+s; entries ≥ Bw*Bh are 0.
- out_err  out  1  config was illegal; all weights are 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high:
  - capture in_grid_u8, Bw, Bh, Gw and Gh into registers;
  - clear out_weights_u8;
  - set s=t=0;
  - go to RUN. If the config is illegal, go straight to DONE with out_err=1 instead.
- A config is illegal if any field is outside its range or Gw*Gh > MAX_GRID.
- RUN: each cycle, compute LANES consecutive texels starting at (s,t).
  - Advance s and t incrementally: s wraps at Bw, then t increments. No divider.
  - Lanes whose index is ≥ Bw*Bh are masked and write nothing.
  - Go to DONE after the cycle that covers the last texel.
- Per-texel arithmetic, all unsigned:
  - Ds comes from a ROM indexed by Bw, equal to (1024+Bw/2)/(Bw-1): 4→342, 5→256, 6→205, 7→171, 8→146, 9→128, 10→114, 11→102, 12→93. Dt uses the same ROM indexed by Bh.
  - gs = (Ds*s*(Gw-1)+32)>>6; js = gs>>4; fs = gs&15. gt, jt and ft are computed the same way using Dt, t and Gh.
  - v0 = js + jt*Gw. Taps: p00=w[v0], p01=w[v0+1], p10=w[v0+Gw], p11=w[v0+Gw+1].
  - A tap whose grid column > Gw-1 or grid row > Gh-1 reads 0. Its coefficient is always 0 in that case, so this is only a bounds guard.
  - w11 = (fs*ft+8)>>4; w10 = ft-w11; w01 = fs-w11; w00 = 16-fs-ft+w11.
  - result = (p00*w00 + p01*w01 + p10*w10 + p11*w11 + 8)>>4. Use a 13-bit accumulator. The result always fits in 8 bits (convex combination), so no clamp.
- DONE: out_valid=1. out_weights_u8 and out_err must hold stable until out_ready. On the cycle with out_valid && out_ready, go to IDLE. out_valid deasserts and out_weights_u8 holds its last value.
- in_ready is 0 in RUN and DONE. A new block can be accepted no earlier than the cycle after the output handshake.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_err=0, out_weights_u8=0, all internal registers 0.
- Latency: acceptance at edge E0; RUN occupies N = ceil(Bw*Bh/LANES) cycles; out_valid is high after edge E0+N.
  - Example: 4x4 with LANES=4 gives N=4.
  - An illegal config gives out_valid after E0+1.
- Throughput: one block per N+2 cycles when out_ready is held high.
- in_valid in RUN or DONE is ignored; it is not an error.
- rst_n asserted mid-RUN or mid-DONE: immediately return to reset values; any partial result is discarded.
- out_ready toggling during RUN has no effect.

## Test plan
- 4x4 block, 4x4 grid, weights 0..15 times 4 -> output equals input (identity mapping); out_valid after 4 RUN cycles.
- 4x4 block, 2x2 grid, w={0,64,0,64} -> every texel row is 0,20,44,64; out_err=0.
- 12x12 block, 8x8 grid, all weights 200 -> all 144 outputs are 200. With LANES=4 there are 36 RUN cycles.
- 5x5 block (25 texels, partial last beat), 3x3 grid, random weights -> matches the reference model; entries 25..143 are 0.
- Grid 9x8 (72 > MAX_GRID), then separately Bw=3 -> out_err=1, all outputs 0, out_valid one cycle after acceptance.
- out_ready held low for 10 cycles in DONE -> outputs stable and in_ready=0. rst_n pulsed mid-RUN -> outputs return to reset values, and the next block decodes correctly.
